// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
// S_PARITY is only used when SIPO_PARITY_EN is defined.
package sipo_pkg;

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_PARITY  = 1'b1
  } state_t;

  // Bit-counter width for a word of w bits (never narrower than one bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Even-parity reduction over a zero-extended word.
  function automatic logic parity_of(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// Output holding register for assembled words: load/accept handshake,
// sticky overflow on dropped words, and the per-word parity result.
module sipo_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             perr_in,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             parity_err,
  output logic             overflow
);

  logic accept_s;
  logic take_s;
  logic drop_s;

  // A new word is taken when the buffer is empty or is being drained on this edge.
  always_comb begin
    accept_s = dout_valid & ready;
    if (load) begin
      take_s = ~dout_valid | accept_s;
      drop_s = dout_valid & ~accept_s;
    end else begin
      take_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  // Holding register and sticky overflow; clr leaves a pending word intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= {WIDTH{1'b0}};
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (take_s) begin
        dout       <= word;
        dout_valid <= 1'b1;
        parity_err <= perr_in;
      end else if (accept_s) begin
        dout_valid <= 1'b0;
      end
      if (clr) begin
        overflow <= 1'b0;
      end else if (drop_s) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with valid/ready output handshake.
// Define SIPO_PARITY_EN to expect one parity bit after every data word.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overflow,
  output logic             parity_err
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg_r;
  logic [WIDTH-1:0] sreg_next_s;
  logic [WIDTH-1:0] shift_s;
  logic [WIDTH-1:0] word_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_next_s;
  logic             busy_r;
  logic             busy_next_s;
  logic             load_s;
  logic             perr_s;
`ifdef SIPO_PARITY_EN
  state_t           state_r;
  state_t           state_next_s;
`endif

  // Shift register input ordering.
  always_comb begin
    if (MSB_FIRST != 0) begin
      shift_s = {sreg_r[WIDTH-2:0], din};
    end else begin
      shift_s = {din, sreg_r[WIDTH-1:1]};
    end
  end

  // Next-state for shifter, bit counter and (optional) parity phase.
  always_comb begin
    sreg_next_s = sreg_r;
    cnt_next_s  = cnt_r;
    load_s      = 1'b0;
`ifdef SIPO_PARITY_EN
    state_next_s = state_r;
    // In S_PARITY the full word already sits in sreg_r and din is the parity bit.
    word_s       = sreg_r;
    perr_s       = (parity_of(64'(sreg_r)) ^ din) != (PARITY_ODD != 0);
`else
    word_s       = shift_s;
    perr_s       = 1'b0;
`endif
    if (clr) begin
      sreg_next_s = {WIDTH{1'b0}};
      cnt_next_s  = {CW{1'b0}};
`ifdef SIPO_PARITY_EN
      state_next_s = S_COLLECT;
`endif
    end else if (din_valid) begin
`ifdef SIPO_PARITY_EN
      case (state_r)
        S_COLLECT: begin
          sreg_next_s = shift_s;
          if (cnt_r == LAST_BIT) begin
            cnt_next_s   = {CW{1'b0}};
            state_next_s = S_PARITY;
          end else begin
            cnt_next_s = cnt_r + CW'(1);
          end
        end
        S_PARITY: begin
          state_next_s = S_COLLECT;
          load_s       = 1'b1;
        end
        default: begin
          state_next_s = S_COLLECT;
        end
      endcase
`else
      sreg_next_s = shift_s;
      if (cnt_r == LAST_BIT) begin
        cnt_next_s = {CW{1'b0}};
        load_s     = 1'b1;
      end else begin
        cnt_next_s = cnt_r + CW'(1);
      end
`endif
    end else begin
      sreg_next_s = sreg_r;
    end
`ifdef SIPO_PARITY_EN
    busy_next_s = (cnt_next_s != {CW{1'b0}}) || (state_next_s == S_PARITY);
`else
    busy_next_s = (cnt_next_s != {CW{1'b0}});
`endif
  end

  // Collection state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
`ifdef SIPO_PARITY_EN
      state_r <= S_COLLECT;
`endif
    end else begin
      sreg_r  <= sreg_next_s;
      cnt_r   <= cnt_next_s;
      busy_r  <= busy_next_s;
`ifdef SIPO_PARITY_EN
      state_r <= state_next_s;
`endif
    end
  end

  assign busy = busy_r;

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .load      (load_s),
    .word      (word_s),
    .perr_in   (perr_s),
    .ready     (dout_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .parity_err(parity_err),
    .overflow  (overflow)
  );

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter: WIDTH, 8, assembled word width in bits; legal range 2..64.
REQ-002 Parameter: MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0].
REQ-003 Parameter: PARITY_ODD, 0, parity sense when parity is compiled in; 0 = even, 1 = odd.
REQ-004 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: clr  input  1  synchronous clear of the in-progress word and the overflow flag.
REQ-007 Port: din  input  1  serial data bit.
REQ-008 Port: din_valid  input  1  din is sampled only when din_valid=1.
REQ-009 Port: dout  output  WIDTH  assembled word, held stable while dout_valid=1.
REQ-010 Port: dout_valid  output  1  a word is available.
REQ-011 Port: dout_ready  input  1  consumer accepts the word when dout_valid=1 and dout_ready=1.
REQ-012 Port: busy  output  1  high while a partial word is held (bit count nonzero, or in S_PARITY).
REQ-013 Port: overflow  output  1  sticky flag: a completed word was dropped.
REQ-014 Port: parity_err  output  1  parity check result, qualified by dout_valid.

Function
REQ-015 State machine: S_COLLECT (shifting data bits); S_PARITY (waiting for the parity bit, exists only with the macro).
- S_COLLECT -> S_PARITY on the WIDTH-th data bit.
- S_PARITY -> S_COLLECT on the parity bit.
REQ-016 Shifting: each clk edge with din_valid=1 shifts one bit in.
- MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], din}.
- MSB_FIRST=0: sreg <= {din, sreg[WIDTH-1:1]}.
- din_valid=0 holds sreg and the bit counter; gaps are unbounded.
REQ-017 The bit counter is $clog2(WIDTH) bits wide, counts 0..WIDTH-1 and wraps to 0 on word completion.
REQ-018 Word completion: on the edge that samples the final bit, dout is loaded with the full word including that bit.
- dout_valid=1 from the next cycle; latency is 1 cycle from the last sample.
- Back-to-back words with no idle cycles are supported.
REQ-019 Handshake: dout_valid stays high until accepted; acceptance without a new completion clears dout_valid on that edge.
REQ-020 Completion while dout_valid=1 and no accept on that edge: the new word is dropped, dout is unchanged, and overflow is set.
REQ-021 Completion on the same edge as an accept: the new word loads, dout_valid stays 1, and overflow is not set.
REQ-022 clr=1 takes priority over din_valid:
- Clears sreg, the bit counter, the state (to S_COLLECT) and overflow.
- Does not clear dout or dout_valid, so a pending word survives.
REQ-023 overflow is cleared only by rst or clr.

Reset
REQ-024 rst=1 asynchronously forces the following, independent of clk:
- sreg=0, bit counter=0, state=S_COLLECT
- dout=0, dout_valid=0, busy=0, overflow=0, parity_err=0
REQ-025 The first edge after rst deasserts samples the bit that becomes bit 0 of a new word; a partial word interrupted by reset is discarded.

Configuration
REQ-026 Macro SIPO_PARITY_EN defined: each word is followed by one parity bit.
- Completion moves to the parity-bit edge.
- parity_err is loaded with dout: 1 when (^word ^ parity_bit) != PARITY_ODD.
- busy stays high in S_PARITY.
REQ-027 Macro SIPO_PARITY_EN undefined:
- S_PARITY is not built.
- parity_err is tied to 0; the port is still present.
- PARITY_ODD is ignored.

Structure
REQ-028 Package sipo_pkg holds the state typedef (S_COLLECT, S_PARITY) and the counter-width helper function.
REQ-029 Sub-module sipo_out_buf holds dout, dout_valid, parity_err and overflow, with load/accept logic per REQ-018..REQ-023; sipo_deser instantiates it once.

Verification
REQ-030 The bench shall cover these directed scenarios, at WIDTH=8:
- MSB_FIRST=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles, dout_ready=1 -> dout=8'hB2, dout_valid high for exactly 1 cycle, 1 cycle after the 8th sample.
- MSB_FIRST=0, same bit stream -> dout=8'h4D.
- MSB_FIRST=1, din_valid low for 3 cycles after the 4th bit -> dout=8'hB2; busy high during the gap.
- dout_ready=0, word 8'hB2 then word 8'hFF -> dout remains 8'hB2 and overflow=1; then dout_ready=1 -> dout_valid drops, overflow stays 1 until clr.
- rst asserted after 5 bits, then 8 bits of 8'hA5 -> dout=8'hA5, no overflow, no stale bits.
- SIPO_PARITY_EN, PARITY_ODD=0, word 8'hB2:
  - Parity bit 0 -> parity_err=0.
  - Parity bit 1 -> parity_err=1.
